bcd_cascade_counter: RTL and testbench

Parametrised multi-digit modulo counter: DIGITS cascaded digits, each counting 0..RADIX-1, with count enable, up/down direction, synchronous load and clear, wrap or saturate mode, and a registered carry/borrow pulse. It is the general-purpose event counter for the weather-station FPGA (rain-gauge tips, anemometer pulses, display digit counts) and can be chained through `carry`.

---
 rtl/cnt_pkg.sv | 14 +
 rtl/digit_counter.sv | 43 ++++
 rtl/bcd_cascade_counter.sv | 82 ++++++++
 tb/tb_bcd_cascade_counter.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/cnt_pkg.sv
// Shared constants and helpers for the cascaded modulo counter family.
// Direction/mode encodings and the per-digit validity check live here.
package cnt_pkg;

  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  function automatic logic digit_valid(input logic [31:0] d, input logic [31:0] radix);
    return d < radix;
  endfunction

endpackage

// File: rtl/digit_counter.sv
// One modulo-RADIX digit of the cascade. Steps only when the top says so;
// clear and load take priority over stepping, invalid load fields become 0.
module digit_counter
  import cnt_pkg::*;
#(
  parameter int RADIX = 10,
  parameter int DW    = 4
) (
  input  logic          clk_in,
  input  logic          rst,
  input  logic          step,
  input  logic          up,
  input  logic          clr,
  input  logic          load,
  input  logic [DW-1:0] load_digit,
  output logic [DW-1:0] digit,
  output logic          is_max,
  output logic          is_zero
);

  localparam logic [DW-1:0] MAX = DW'(RADIX - 1);
  localparam logic [DW-1:0] ONE = DW'(1);

  logic load_ok;
  assign load_ok = digit_valid(32'(load_digit), 32'(RADIX));

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      digit <= '0;
    end else if (clr) begin
      digit <= '0;
    end else if (load) begin
      digit <= load_ok ? load_digit : '0;
    end else if (step) begin
      if (up == DIR_UP) digit <= is_max  ? '0  : digit + ONE;
      else              digit <= is_zero ? MAX : digit - ONE;
    end
  end

  assign is_max  = (digit == MAX);
  assign is_zero = (digit == '0);

endmodule

// File: rtl/bcd_cascade_counter.sv
// Multi-digit modulo counter: digits cascade in one cycle via prefix-ANDed
// step enables; wrap/saturate gating and the carry/load_err pulses live here.
module bcd_cascade_counter
  import cnt_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int RADIX    = 10,
  parameter int DW       = 4,
  parameter int SATURATE = 0
) (
  input  logic                 clk_in,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 up,
  input  logic                 clr,
  input  logic                 load,
  input  logic [DIGITS*DW-1:0] load_val,
  output logic [DIGITS*DW-1:0] cnt,
  output logic                 carry,
  output logic                 at_max,
  output logic                 at_zero,
  output logic                 load_err
);

  localparam logic MODE = (SATURATE != 0) ? MODE_SAT : MODE_WRAP;

  logic [DIGITS-1:0] is_max;
  logic [DIGITS-1:0] is_zero;
  logic [DIGITS-1:0] step;
  logic [DIGITS-1:0] bad_digit;
  logic              end_hit;
  logic              count_en;

  assign at_max  = &is_max;
  assign at_zero = &is_zero;

  // The end in the current direction; saturate mode freezes the count there.
  assign end_hit  = (up == DIR_UP) ? at_max : at_zero;
  assign count_en = en & ~((MODE == MODE_SAT) & end_hit);

  always_comb begin
    logic run;
    run  = count_en;
    step = '0;
    for (int i = 0; i < DIGITS; i++) begin
      step[i] = run;
      run     = run & ((up == DIR_UP) ? is_max[i] : is_zero[i]);
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    assign bad_digit[g] = ~digit_valid(32'(load_val[g*DW +: DW]), 32'(RADIX));

    digit_counter #(
      .RADIX (RADIX),
      .DW    (DW)
    ) u_digit (
      .clk_in     (clk_in),
      .rst        (rst),
      .step       (step[g]),
      .up         (up),
      .clr        (clr),
      .load       (load),
      .load_digit (load_val[g*DW +: DW]),
      .digit      (cnt[g*DW +: DW]),
      .is_max     (is_max[g]),
      .is_zero    (is_zero[g])
    );
  end

  // Pulses line up with the cnt value produced by the same edge.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      carry    <= 1'b0;
      load_err <= 1'b0;
    end else begin
      carry    <= ~clr & ~load & en & end_hit & (MODE == MODE_WRAP);
      load_err <= ~clr & load & (|bad_digit);
    end
  end

endmodule

// File: tb/tb_bcd_cascade_counter.sv
// Random and directed stimulus for three counter configurations sharing
// one input set, each checked against an integer-valued reference model.
module tb_bcd_cascade_counter;

  logic        clk_in = 1'b0;
  logic        rst, en, up, clr, load;
  logic [11:0] lv;

  logic [7:0]  a_cnt, b_cnt;
  logic [11:0] c_cnt;
  logic        a_carry, a_max, a_zero, a_lerr;
  logic        b_carry, b_max, b_zero, b_lerr;
  logic        c_carry, c_max, c_zero, c_lerr;

  int errors = 0;
  int checks = 0;
  int va, vb, vc;
  bit ca, cb, cc, la, lb, lc;

  always #5 clk_in = ~clk_in;

  bcd_cascade_counter #(.DIGITS(2), .RADIX(10), .DW(4), .SATURATE(0)) u_a (
    .clk_in(clk_in), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(lv[7:0]), .cnt(a_cnt), .carry(a_carry), .at_max(a_max),
    .at_zero(a_zero), .load_err(a_lerr));

  bcd_cascade_counter #(.DIGITS(2), .RADIX(10), .DW(4), .SATURATE(1)) u_b (
    .clk_in(clk_in), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(lv[7:0]), .cnt(b_cnt), .carry(b_carry), .at_max(b_max),
    .at_zero(b_zero), .load_err(b_lerr));

  bcd_cascade_counter #(.DIGITS(3), .RADIX(6), .DW(4), .SATURATE(0)) u_c (
    .clk_in(clk_in), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(lv), .cnt(c_cnt), .carry(c_carry), .at_max(c_max),
    .at_zero(c_zero), .load_err(c_lerr));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Counter value as an integer 0..RADIX^DIGITS-1; the packed form is derived.
  function automatic logic [11:0] pack(input int v, input int d, input int r);
    logic [11:0] p;
    int x;
    p = '0;
    x = v;
    for (int i = 0; i < d; i++) begin
      p[i*4 +: 4] = 4'(x % r);
      x = x / r;
    end
    return p;
  endfunction

  task automatic model_step(input int v, input int d, input int r, input bit sat,
                            output int nv, output bit cy, output bit le);
    int n, mul, dig;
    n  = r ** d;
    nv = v;
    cy = 1'b0;
    le = 1'b0;
    if (clr) begin
      nv = 0;
    end else if (load) begin
      nv  = 0;
      mul = 1;
      for (int i = 0; i < d; i++) begin
        dig = int'((lv >> (4 * i)) & 12'hF);
        if (dig >= r) begin
          dig = 0;
          le  = 1'b1;
        end
        nv  = nv + dig * mul;
        mul = mul * r;
      end
    end else if (en) begin
      if (up) begin
        if (v == n - 1) begin
          if (!sat) begin nv = 0; cy = 1'b1; end
        end else nv = v + 1;
      end else begin
        if (v == 0) begin
          if (!sat) begin nv = n - 1; cy = 1'b1; end
        end else nv = v - 1;
      end
    end
  endtask

  task automatic check_all();
    chk("a_cnt",   32'(a_cnt),   32'(pack(va, 2, 10)));
    chk("a_carry", 32'(a_carry), 32'(ca));
    chk("a_lerr",  32'(a_lerr),  32'(la));
    chk("a_max",   32'(a_max),   32'(va == 99));
    chk("a_zero",  32'(a_zero),  32'(va == 0));
    chk("b_cnt",   32'(b_cnt),   32'(pack(vb, 2, 10)));
    chk("b_carry", 32'(b_carry), 32'(cb));
    chk("b_lerr",  32'(b_lerr),  32'(lb));
    chk("b_max",   32'(b_max),   32'(vb == 99));
    chk("b_zero",  32'(b_zero),  32'(vb == 0));
    chk("c_cnt",   32'(c_cnt),   32'(pack(vc, 3, 6)));
    chk("c_carry", 32'(c_carry), 32'(cc));
    chk("c_lerr",  32'(c_lerr),  32'(lc));
    chk("c_max",   32'(c_max),   32'(vc == 215));
    chk("c_zero",  32'(c_zero),  32'(vc == 0));
  endtask

  task automatic tick();
    int na, nb, nc;
    @(posedge clk_in);
    model_step(va, 2, 10, 1'b0, na, ca, la);
    model_step(vb, 2, 10, 1'b1, nb, cb, lb);
    model_step(vc, 3, 6,  1'b0, nc, cc, lc);
    va = na; vb = nb; vc = nc;
    #1;
    check_all();
  endtask

  task automatic set_in(input bit e, input bit u, input bit c, input bit l, input logic [11:0] v);
    en = e; up = u; clr = c; load = l; lv = v;
  endtask

  task automatic model_reset();
    va = 0; vb = 0; vc = 0;
    ca = 0; cb = 0; cc = 0; la = 0; lb = 0; lc = 0;
  endtask

  initial begin
    int ncarry;
    rst = 1'b1;
    set_in(0, 1, 0, 0, 12'h000);
    model_reset();
    repeat (2) @(posedge clk_in);
    #1;
    check_all();
    @(negedge clk_in);
    rst = 1'b0;

    // Scenario 1: full up sweep, one carry with the 00 after 99.
    set_in(1, 1, 0, 0, 12'h000);
    ncarry = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (a_carry) ncarry++;
    end
    chk("s1_carry_count", 32'(ncarry), 32'd1);
    chk("s1_end_cnt", 32'(a_cnt), 32'h00);

    // Scenario 2: down from 00 wraps to 99, then borrows through 90->89.
    set_in(0, 1, 0, 1, 12'h000);
    tick();
    set_in(1, 0, 0, 0, 12'h000);
    tick();
    chk("s2_wrap_99", 32'(a_cnt), 32'h99);
    chk("s2_wrap_carry", 32'(a_carry), 32'd1);
    repeat (12) tick();

    // Scenario 3: saturation at both ends.
    set_in(0, 1, 0, 1, 12'h098);
    tick();
    set_in(1, 1, 0, 0, 12'h000);
    repeat (5) tick();
    chk("s3_sat_hi", 32'(b_cnt), 32'h99);
    set_in(0, 1, 0, 1, 12'h001);
    tick();
    set_in(1, 0, 0, 0, 12'h000);
    repeat (3) tick();
    chk("s3_sat_lo", 32'(b_cnt), 32'h00);

    // Scenario 4: invalid digit loads as 0; load beats en.
    set_in(1, 1, 0, 1, 12'h0A3);
    tick();
    chk("s4_cnt", 32'(a_cnt), 32'h03);
    chk("s4_lerr", 32'(a_lerr), 32'd1);
    set_in(0, 1, 0, 0, 12'h000);
    tick();
    chk("s4_lerr_drop", 32'(a_lerr), 32'd0);

    // Scenario 5: clr+load+en at 99 suppresses carry; async reset at 57.
    set_in(0, 1, 0, 1, 12'h099);
    tick();
    set_in(1, 1, 1, 1, 12'h055);
    tick();
    chk("s5_clr_cnt", 32'(a_cnt), 32'h00);
    chk("s5_clr_carry", 32'(a_carry), 32'd0);
    set_in(0, 1, 0, 1, 12'h057);
    tick();
    set_in(1, 1, 0, 0, 12'h000);
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("s5_async_cnt", 32'(a_cnt), 32'h00);
    chk("s5_async_zero", 32'(a_zero), 32'd1);
    check_all();
    #1 rst = 1'b0;
    repeat (3) tick();

    // Scenario 6: random enable, direction flips every 7 cycles, rare load/clr.
    up = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (i % 7 == 0) up = ~up;
      en   = 1'($urandom_range(0, 1));
      load = ($urandom_range(0, 31) == 0);
      clr  = ($urandom_range(0, 63) == 0);
      lv   = 12'($urandom);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
